// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants for the regfile writeback arbiter: register-file geometry,
// default sizing and the fixed writeback source indices.
package regfile_wb_arbiter_pkg;

    localparam int unsigned REG_ADDR_W    = 5;
    localparam int unsigned NUM_ARCH_REGS = 32;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

    localparam int unsigned DEFAULT_WIDTH   = 32;
    localparam int unsigned DEFAULT_NUM_REQ = 4;

    localparam int unsigned WB_ALU    = 0;
    localparam int unsigned WB_MUL    = 1;
    localparam int unsigned WB_LSU    = 2;
    localparam int unsigned WB_COMMIT = 3;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bus plus the registered regfile write port.
// The master side is the set of writeback sources; the slave side is the arbiter.
interface regfile_wb_arbiter_if
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH   = DEFAULT_WIDTH,
    parameter int unsigned NUM_REQ = DEFAULT_NUM_REQ,
    parameter int unsigned GRANT_W = $clog2(NUM_REQ)
);

    logic [NUM_REQ-1:0]            req_valid;
    logic [REG_ADDR_W*NUM_REQ-1:0] req_addr;
    logic [WIDTH*NUM_REQ-1:0]      req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          hold;

    logic                  rf_w_en;
    logic [REG_ADDR_W-1:0] rf_rd_addr;
    logic [WIDTH-1:0]      rf_w_data;
    logic [GRANT_W-1:0]    grant_id;
    logic                  conflict;

    modport master (
        output req_valid, req_addr, req_data, hold,
        input  req_ready, rf_w_en, rf_rd_addr, rf_w_data, grant_id, conflict
    );

    modport slave (
        input  req_valid, req_addr, req_data, hold,
        output req_ready, rf_w_en, rf_rd_addr, rf_w_data, grant_id, conflict
    );

endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Generic combinational round-robin picker: first set request at or after ptr,
// wrapping modulo NUM_REQ. Reusable wherever a single winner per cycle is needed.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               valid_o
);

    int unsigned      cand;
    logic [IDX_W-1:0] cand_idx;

    always_comb begin
        gnt_o    = '0;
        idx_o    = '0;
        valid_o  = 1'b0;
        cand     = 0;
        cand_idx = '0;
        if (en_i) begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                cand = 32'(ptr_i) + k;
                if (cand >= NUM_REQ) begin
                    cand = cand - NUM_REQ;
                end
                cand_idx = IDX_W'(cand);
                if (!valid_o && req_i[cand_idx]) begin
                    valid_o         = 1'b1;
                    gnt_o[cand_idx] = 1'b1;
                    idx_o           = cand_idx;
                end
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the regfile's single write port among the
// writeback sources; the winning write reaches the regfile one cycle later.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH   = DEFAULT_WIDTH,
    parameter int unsigned NUM_REQ = DEFAULT_NUM_REQ,
    parameter int unsigned GRANT_W = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset,
    regfile_wb_arbiter_if.slave bus
);

    logic [NUM_REQ-1:0] gnt;
    logic [GRANT_W-1:0] win_idx;
    logic               win_valid;

    logic [REG_ADDR_W-1:0] win_addr;
    logic [WIDTH-1:0]      win_data;
    logic                  clash;

    logic [GRANT_W-1:0]    ptr_q,        ptr_d;
    logic                  rf_w_en_q,    rf_w_en_d;
    logic [REG_ADDR_W-1:0] rf_rd_addr_q, rf_rd_addr_d;
    logic [WIDTH-1:0]      rf_w_data_q,  rf_w_data_d;
    logic [GRANT_W-1:0]    grant_id_q,   grant_id_d;
    logic                  conflict_q,   conflict_d;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (GRANT_W)
    ) u_rr (
        .req_i   (bus.req_valid),
        .ptr_i   (ptr_q),
        .en_i    (!bus.hold && !reset),
        .gnt_o   (gnt),
        .idx_o   (win_idx),
        .valid_o (win_valid)
    );

    assign bus.req_ready = gnt;

    // Winner payload is muxed by the one-hot grant, then compared against losers.
    always_comb begin
        win_addr = '0;
        win_data = '0;
        clash    = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                win_addr = bus.req_addr[i*REG_ADDR_W +: REG_ADDR_W];
                win_data = bus.req_data[i*WIDTH +: WIDTH];
            end
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!gnt[i] && bus.req_valid[i] &&
                bus.req_addr[i*REG_ADDR_W +: REG_ADDR_W] == win_addr &&
                win_addr != ZERO_REG) begin
                clash = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d        = ptr_q;
        rf_w_en_d    = 1'b0;
        rf_rd_addr_d = rf_rd_addr_q;
        rf_w_data_d  = rf_w_data_q;
        grant_id_d   = grant_id_q;
        conflict_d   = 1'b0;
        if (win_valid) begin
            ptr_d        = (32'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + GRANT_W'(1);
            rf_w_en_d    = (win_addr != ZERO_REG);
            rf_rd_addr_d = win_addr;
            rf_w_data_d  = win_data;
            grant_id_d   = win_idx;
            conflict_d   = clash;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q        <= '0;
            rf_w_en_q    <= 1'b0;
            rf_rd_addr_q <= '0;
            rf_w_data_q  <= '0;
            grant_id_q   <= '0;
            conflict_q   <= 1'b0;
        end else begin
            ptr_q        <= ptr_d;
            rf_w_en_q    <= rf_w_en_d;
            rf_rd_addr_q <= rf_rd_addr_d;
            rf_w_data_q  <= rf_w_data_d;
            grant_id_q   <= grant_id_d;
            conflict_q   <= conflict_d;
        end
    end

    assign bus.rf_w_en    = rf_w_en_q;
    assign bus.rf_rd_addr = rf_rd_addr_q;
    assign bus.rf_w_data  = rf_w_data_q;
    assign bus.grant_id   = grant_id_q;
    assign bus.conflict   = conflict_q;

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single synchronous write port among NUM_REQ writeback sources (ALU, MUL, LSU, commit).
- Each source presents valid/addr/data. One is granted per cycle by round-robin. The winning write is registered and driven to the regfile write port one cycle later.
- Sits between the functional-unit writeback buses and the 2r1w register file.

Parameters:
- WIDTH, 32, data width of a register write.
- NUM_REQ, 4, number of writeback requesters (2..8).
- GRANT_W, 2, width of the grant index; equals clog2(NUM_REQ).

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- req_valid  input  NUM_REQ  per-requester write request
- req_addr  input  5*NUM_REQ  destination register; requester i at bits [5i+4:5i]
- req_data  input  WIDTH*NUM_REQ  write data; requester i at bits [WIDTH*i+WIDTH-1:WIDTH*i]
- req_ready  output  NUM_REQ  one-hot or zero; requester i accepted this cycle
- hold  input  1  blocks all grants this cycle (e.g. pipeline drain)
- rf_w_en  output  1  regfile write enable
- rf_rd_addr  output  5  regfile write address
- rf_w_data  output  WIDTH  regfile write data
- grant_id  output  GRANT_W  index of the requester whose write is on rf_* this cycle
- conflict  output  1  pulse: same-cycle losers include a request to the same non-zero rd as the winner

Behaviour:
- Clock and reset: reset is synchronous, active-high; clock is clk.
- Reset values:
  - rf_w_en=0, rf_rd_addr=0, rf_w_data=0, grant_id=0, conflict=0.
  - Round-robin pointer ptr=0.
- While reset is high, req_ready=0 and nothing is accepted.
- Arbitration (combinational, same cycle):
  - If hold=1 or reset=1, req_ready=0.
  - Otherwise scan indices ptr, ptr+1, ..., wrapping mod NUM_REQ. The first i with req_valid[i]=1 gets req_ready[i]=1.
  - At most one bit of req_ready is set. req_ready may depend combinationally on req_valid.
  - A transfer occurs when req_valid[i] & req_ready[i].
- Requesters must hold valid/addr/data stable until accepted. The arbiter never drops a held request.
- Pointer update, on a transfer from i: ptr <= (i+1) mod NUM_REQ. With no transfer, ptr is unchanged.
- Output register, 1-cycle latency. The cycle after a transfer from i:
  - rf_w_en = (req_addr_i != 0).
  - rf_rd_addr = req_addr_i.
  - rf_w_data = req_data_i.
  - grant_id = i.
- With no transfer, rf_w_en <= 0; rf_rd_addr, rf_w_data and grant_id hold their previous values.
- x0 writes:
  - Accepted and consume the grant slot; pointer advances.
  - rf_w_en stays 0.
  - Never flagged as conflict.
- conflict: registered alongside the output. Set to 1 if some other valid requester this cycle had the same non-zero addr as the winner.
  - Informational only; the winner still writes, and the loser is served later in round-robin order.
- Throughput: one write per cycle sustained. With all NUM_REQ valid, each requester is served exactly once per NUM_REQ cycles. No starvation.
- hold asserted mid-stream: the in-flight registered write still completes on the next cycle; no new grants.
- Reset during activity:
  - The in-flight registered write is discarded; rf_w_en=0 the next cycle.
  - Pending requests are not accepted and must be re-presented.

Decomposition:
- Shared package holds:
  - REG_ADDR_W=5, NUM_ARCH_REGS=32, ZERO_REG=5'd0.
  - Default WIDTH and NUM_REQ, and the requester index constants WB_ALU=0, WB_MUL=1, WB_LSU=2, WB_COMMIT=3.
- One natural sub-module: rr_arbiter.
  - Generic NUM_REQ round-robin picker.
  - Inputs: req vector, ptr, enable. Outputs: one-hot grant and encoded index.
  - Purely combinational, reusable for the issue-queue select.
- The pointer register, output register and conflict detect live in regfile_wb_arbiter.

Test Plan:
- Single requester: after reset, req_valid=4'b0100, addr=7, data=0xDEADBEEF → req_ready=4'b0100 same cycle; next cycle rf_w_en=1, rf_rd_addr=7, rf_w_data=0xDEADBEEF, grant_id=2; ptr=3.
- All four held valid for 8 cycles from ptr=0 → grant order 0,1,2,3,0,1,2,3; rf_w_en=1 on cycles 1..8.
- x0 write: requester 1 valid, addr=0, data=0x55 → accepted; next cycle rf_w_en=0, grant_id=1; ptr advances to 2.
- Same-rd collision: requesters 0 and 3 both write addr=5, ptr=0 → req 0 wins, next cycle conflict=1 and rf_w_data=req0 data. Following cycle req 3 wins, rf_w_data=req3 data, and conflict=0 (requester 3 is the only valid request that cycle).
- hold: requesters 0..3 valid, hold=1 for 3 cycles → req_ready=0, rf_w_en=0 after the in-flight write completes; on release, grant resumes at the unchanged ptr.
- Reset mid-stream: transfer in cycle N, reset=1 in cycle N+1 → rf_w_en=0 in N+2, ptr=0, req_ready=0 throughout reset.
